// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial diff = sum_in - a_in, LSB first, start/ready in, done pulse out.
// Optional SERIAL_SUB_RANGE_CHECK_EN adds range_err (result is not a valid WIDTH-bit addend).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH:0]   sum_in,
  input  logic [WIDTH-1:0] a_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH:0]   diff,
  output logic             borrow
`ifdef SERIAL_SUB_RANGE_CHECK_EN
  ,
  output logic             range_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]  min_q, min_d;
  logic [WIDTH:0]  sub_q, sub_d;
  logic [WIDTH:0]  res_q, res_d;
  logic            bor_q, bor_d;
  logic [WIDTH:0]  diff_q, diff_d;
  logic            borrow_q, borrow_d;
  logic            done_q, done_d;
  logic            bit_m, bit_s, bit_d, bor_next;
`ifdef SERIAL_SUB_RANGE_CHECK_EN
  logic            range_err_q, range_err_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    min_d    = min_q;
    sub_d    = sub_q;
    res_d    = res_q;
    bor_d    = bor_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_RANGE_CHECK_EN
    range_err_d = range_err_q;
`endif
    bit_m    = min_q[0];
    bit_s    = sub_q[0];
    bit_d    = bit_m ^ bit_s ^ bor_q;
    bor_next = (~bit_m & bit_s) | (~(bit_m ^ bit_s) & bor_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          min_d   = sum_in;
          sub_d   = {1'b0, a_in};
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        min_d = min_q >> 1;
        sub_d = sub_q >> 1;
        res_d = {bit_d, res_q[WIDTH:1]};
        bor_d = bor_next;
        cnt_d = cnt_q + CW'(1);
        // Final bit: publish the fully assembled result and free the unit.
        if (cnt_q == LAST) begin
          diff_d   = res_d;
          borrow_d = bor_next;
          done_d   = 1'b1;
          state_d  = IDLE;
`ifdef SERIAL_SUB_RANGE_CHECK_EN
          range_err_d = bor_next | bit_d;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      min_q    <= '0;
      sub_q    <= '0;
      res_q    <= '0;
      bor_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_RANGE_CHECK_EN
      range_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      min_q    <= min_d;
      sub_q    <= sub_d;
      res_q    <= res_d;
      bor_q    <= bor_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_RANGE_CHECK_EN
      range_err_q <= range_err_d;
`endif
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_RANGE_CHECK_EN
  assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor.
// Reference model: plain integer subtraction modulo 2^(WIDTH+1).
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH:0]   sum_in;
  logic [WIDTH-1:0] a_in;
  logic             ready;
  logic             done;
  logic [WIDTH:0]   diff;
  logic             borrow;
`ifdef SERIAL_SUB_RANGE_CHECK_EN
  logic             range_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH:0] exp_diff;
  logic           exp_borrow;
  logic           exp_rerr;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .sum_in(sum_in),
    .a_in(a_in),
    .ready(ready),
    .done(done),
    .diff(diff),
    .borrow(borrow)
`ifdef SERIAL_SUB_RANGE_CHECK_EN
    ,
    .range_err(range_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [WIDTH:0] s, input logic [WIDTH-1:0] a);
    int unsigned full;
    full       = int'(s) - int'(a) + (1 << (WIDTH + 1));
    exp_diff   = full[WIDTH:0];
    exp_borrow = (int'(s) < int'(a));
    exp_rerr   = exp_borrow | exp_diff[WIDTH];
  endtask

  task automatic check_result(input string tag);
    check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    check({tag, "_borrow"}, 32'(borrow), 32'(exp_borrow));
`ifdef SERIAL_SUB_RANGE_CHECK_EN
    check({tag, "_range_err"}, 32'(range_err), 32'(exp_rerr));
`endif
  endtask

  // Launch one operation (caller guarantees ready=1) and wait for its done.
  // Returns at the cycle where done is observed high.
  task automatic do_op(input string tag, input logic [WIDTH:0] s, input logic [WIDTH-1:0] a);
    int lat;
    logic [WIDTH:0] held_diff;
    logic           held_borrow;
    logic           ok_ready;
    held_diff   = diff;
    held_borrow = borrow;
    ok_ready    = 1'b1;
    sum_in = s;
    a_in   = a;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    sum_in = 9'($urandom);
    a_in   = 8'($urandom);
    lat = 0;
    while (lat < 30) begin
      if (ready !== 1'b0) ok_ready = 1'b0;
      if (diff !== held_diff || borrow !== held_borrow) begin
        check({tag, "_held_during_shift"}, 32'(diff), 32'(held_diff));
        held_diff   = diff;
        held_borrow = borrow;
      end
      tick();
      lat++;
      if (done === 1'b1) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_busy_ready"}, 32'(ok_ready), 32'd1);
    check({tag, "_ready_at_done"}, 32'(ready), 32'd1);
    model(s, a);
    check_result(tag);
  endtask

  task automatic idle_hold(input string tag, input int n);
    logic [WIDTH:0] d0;
    logic           seen;
    d0   = diff;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done !== 1'b0 || diff !== d0) seen = 1'b1;
    end
    check({tag, "_idle_hold"}, 32'(seen), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    sum_in = '0;
    a_in   = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_RANGE_CHECK_EN
    check("rst_range_err", 32'(range_err), 32'd0);
`endif

    do_op("basic", 9'h0FF, 8'h0F);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    idle_hold("basic", 3);

    do_op("max_a", 9'h1FE, 8'hFF);
    tick();
    do_op("msb_set", 9'h1FF, 8'h00);
    tick();
    do_op("under1", 9'h005, 8'h0A);
    tick();
    do_op("under2", 9'h000, 8'hFF);
    tick();

    // Busy: starts during SHIFT must be ignored.
    begin
      int lat;
      int dones;
      logic ok_ready;
      sum_in = 9'h010;
      a_in   = 8'h01;
      start  = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      dones = 0;
      ok_ready = 1'b1;
      while (lat < 30) begin
        if (ready !== 1'b0) ok_ready = 1'b0;
        start = (lat == 2 || lat == 4);
        sum_in = 9'h0AA;
        a_in   = 8'h55;
        tick();
        lat++;
        if (done === 1'b1) break;
      end
      start = 1'b0;
      check("busy_latency", 32'(lat), 32'(LAT));
      check("busy_ready", 32'(ok_ready), 32'd1);
      model(9'h010, 8'h01);
      check_result("busy");
      for (int i = 0; i < 15; i++) begin
        tick();
        if (done === 1'b1) dones++;
      end
      check("busy_single_done", 32'(dones), 32'd0);
    end

    // Back-to-back: next start in the done cycle.
    do_op("b2b_first", 9'h123, 8'h45);
    do_op("b2b_second", 9'h100, 8'h80);
    tick();

    // Randomized stream, mixing back-to-back and idle gaps.
    for (int i = 0; i < 40; i++) begin
      do_op("rand", 9'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        for (int g = $urandom_range(1, 3); g > 0; g--) tick();
      end
    end
    tick();

    // Reset on the 4th SHIFT cycle aborts the operation.
    begin
      int dones;
      sum_in = 9'h1AB;
      a_in   = 8'h3C;
      start  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_done", 32'(done), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_borrow", 32'(borrow), 32'd0);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (done === 1'b1) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);

      reset  = 1'b1;
      start  = 1'b1;
      sum_in = 9'h0F0;
      a_in   = 8'h01;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check("rst_start_ready", 32'(ready), 32'd1);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (done === 1'b1 || ready !== 1'b1) dones++;
      end
      check("rst_start_not_captured", 32'(dones), 32'd0);
    end

    do_op("after_reset", 9'h0FF, 8'h0F);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
